// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   state_t   : FSM encoding of the divider.
//   QUO_FIELD : index of the quotient field in result_o, in units of WIDTH bits (low half).
//   REM_FIELD : index of the remainder field in result_o, in units of WIDTH bits (high half).
package div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ZERO  = 3'd1,
    CALC  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int QUO_FIELD = 0;
  localparam int REM_FIELD = 1;

endpackage

// File: rtl/div_iter_param_if.sv
// Handshake bundle between the execute stage and the divider.
//   start_i/annul_i/signed_div_i/opdata1_i/opdata2_i : request side (driven by the pipeline)
//   result_o/ready_o/busy_o/div_by_zero_o            : response side (driven by the divider)
// master = pipeline, slave = divider.
interface div_iter_param_if #(
  parameter int WIDTH = 32
);

  logic                   start_i;
  logic                   annul_i;
  logic                   signed_div_i;
  logic [WIDTH-1:0]       opdata1_i;
  logic [WIDTH-1:0]       opdata2_i;
  logic [2*WIDTH-1:0]     result_o;
  logic                   ready_o;
  logic                   busy_o;
  logic                   div_by_zero_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, busy_o, div_by_zero_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o, busy_o, div_by_zero_o
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
//   partial_rem : WIDTH+1-bit partial remainder, already shifted left with the next dividend bit
//   divisor     : WIDTH-bit divisor magnitude
//   next_rem    : partial remainder after the trial subtraction was kept or restored
//   q_bit       : quotient bit produced by this iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   partial_rem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // Trial subtraction at WIDTH+1 bits: a clear top bit means the divisor fit.
  always_comb begin
    diff     = partial_rem - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    next_rem = partial_rem;
    if (q_bit) begin
      next_rem = diff;
    end else begin
      next_rem = partial_rem;
    end
  end

endmodule

// File: rtl/div_iter_param.sv
// Iterative restoring divider (signed/unsigned) for the execute stage.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of div_iter_param_if
//              start_i (level request), annul_i (flush), signed_div_i, opdata1_i (dividend),
//              opdata2_i (divisor) -> result_o {remainder, quotient}, ready_o, busy_o,
//              div_by_zero_o
// Operands and signs are captured on accept; the live inputs are ignored afterwards.
module div_iter_param #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  div_iter_param_if.slave bus
);

  import div_pkg::*;

  localparam int               CNT_W   = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH - 1);

  // Two's-complement negate, modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return (~v) + ONE_W;
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               sign1;
  logic               sign2;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   dividend_raw;
  logic [2*WIDTH:0]   work;        // {partial remainder (WIDTH+1), dividend/quotient (WIDTH)}
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               dbz;

  logic               in_sign1;
  logic               in_sign2;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH:0]     step_rem_in;
  logic [WIDTH:0]     step_rem_out;
  logic               q_bit;
  logic [2*WIDTH:0]   work_next;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               unused_top;

  assign in_sign1 = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign in_sign2 = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign mag1     = in_sign1 ? neg(bus.opdata1_i) : bus.opdata1_i;
  assign mag2     = in_sign2 ? neg(bus.opdata2_i) : bus.opdata2_i;

  // Left shift folded in: remainder picks up the next dividend MSB before the trial subtract.
  assign step_rem_in = work[2*WIDTH-1:WIDTH-1];
  assign work_next   = {step_rem_out, work[WIDTH-2:0], q_bit};
  // The remainder never reaches 2^WIDTH, so the top working bit stays zero.
  assign unused_top  = work[2*WIDTH];

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial_rem (step_rem_in),
    .divisor     (divisor),
    .next_rem    (step_rem_out),
    .q_bit       (q_bit)
  );

  assign quo_fix = (sign1 ^ sign2) ? neg(work[WIDTH-1:0]) : work[WIDTH-1:0];
  assign rem_fix = sign1 ? neg(work[2*WIDTH-1:WIDTH]) : work[2*WIDTH-1:WIDTH];

  assign bus.result_o      = result;
  assign bus.ready_o       = ready;
  assign bus.div_by_zero_o = dbz;
  assign bus.busy_o        = (state != IDLE);

  // Divider FSM: accept, iterate, sign fixup / divide-by-zero result, hold until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= {CNT_W{1'b0}};
      sign1        <= 1'b0;
      sign2        <= 1'b0;
      divisor      <= {WIDTH{1'b0}};
      dividend_raw <= {WIDTH{1'b0}};
      work         <= {(2*WIDTH+1){1'b0}};
      result       <= {(2*WIDTH){1'b0}};
      ready        <= 1'b0;
      dbz          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result <= {(2*WIDTH){1'b0}};
          ready  <= 1'b0;
          dbz    <= 1'b0;
          if (bus.start_i && !bus.annul_i) begin
            sign1        <= in_sign1;
            sign2        <= in_sign2;
            divisor      <= mag2;
            dividend_raw <= bus.opdata1_i;
            work         <= {{(WIDTH+1){1'b0}}, mag1};
            cnt          <= {CNT_W{1'b0}};
            if (bus.opdata2_i == {WIDTH{1'b0}}) begin
              state <= ZERO;
            end else begin
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            work <= work_next;
            cnt  <= cnt + CNT_ONE;
            if (cnt == CNT_END) begin
              state <= FIXUP;
            end else begin
              state <= CALC;
            end
          end
        end
        FIXUP: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            result[QUO_FIELD*WIDTH +: WIDTH] <= quo_fix;
            result[REM_FIELD*WIDTH +: WIDTH] <= rem_fix;
            ready <= 1'b1;
            state <= DONE;
          end
        end
        ZERO: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            result[QUO_FIELD*WIDTH +: WIDTH] <= {WIDTH{1'b1}};
            result[REM_FIELD*WIDTH +: WIDTH] <= dividend_raw;
            dbz   <= 1'b1;
            ready <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (!bus.start_i) begin
            result <= {(2*WIDTH){1'b0}};
            ready  <= 1'b0;
            dbz    <= 1'b0;
            state  <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          result <= {(2*WIDTH){1'b0}};
          ready  <= 1'b0;
          dbz    <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_param.sv
// Directed bench for div_iter_param: a WIDTH=32 and a WIDTH=8 instance share clock and reset.
module tb_div_iter_param;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  div_iter_param_if #(.WIDTH(32)) d32 ();
  div_iter_param_if #(.WIDTH(8))  d8 ();

  div_iter_param #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(d32.slave));
  div_iter_param #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(d8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 32-bit transaction: accept, wait for ready, check, hold, release.
  task automatic do32(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                      input int exp_lat, input logic [63:0] exp_res, input logic exp_dbz,
                      input bit scramble);
    int n;
    bit busy_ok;
    d32.start_i      = 1'b1;
    d32.annul_i      = 1'b0;
    d32.signed_div_i = sgn;
    d32.opdata1_i    = a;
    d32.opdata2_i    = b;
    tick();
    n = 0;
    busy_ok = 1'b1;
    while (!d32.ready_o && n < 200) begin
      if (!d32.busy_o) busy_ok = 1'b0;
      if (scramble && n == 5) begin
        d32.opdata1_i    = 32'h5A5A_1234;
        d32.opdata2_i    = 32'h0000_0000;
        d32.signed_div_i = ~sgn;
      end
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "_busy_run"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, "_res"}, d32.result_o, exp_res);
    chk({tag, "_dbz"}, {63'd0, d32.div_by_zero_o}, {63'd0, exp_dbz});
    tick();
    tick();
    chk({tag, "_hold"}, {d32.ready_o, d32.busy_o, d32.result_o[61:0]},
        {1'b1, 1'b1, exp_res[61:0]});
    d32.start_i = 1'b0;
    tick();
    chk({tag, "_clear"}, {d32.result_o[61:0], d32.ready_o, d32.div_by_zero_o},
        {62'd0, 1'b0, 1'b0});
    chk({tag, "_idle"}, {63'd0, d32.busy_o}, 64'd0);
  endtask

  // Full 8-bit transaction.
  task automatic do8(input string tag, input logic sgn, input logic [7:0] a, input logic [7:0] b,
                     input int exp_lat, input logic [15:0] exp_res, input logic exp_dbz);
    int n;
    d8.start_i      = 1'b1;
    d8.annul_i      = 1'b0;
    d8.signed_div_i = sgn;
    d8.opdata1_i    = a;
    d8.opdata2_i    = b;
    tick();
    n = 0;
    while (!d8.ready_o && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "_res"}, {48'd0, d8.result_o}, {48'd0, exp_res});
    chk({tag, "_dbz"}, {63'd0, d8.div_by_zero_o}, {63'd0, exp_dbz});
    d8.start_i = 1'b0;
    tick();
    chk({tag, "_clear"}, {46'd0, d8.result_o, d8.ready_o, d8.busy_o}, 64'd0);
  endtask

  initial begin
    bit rose;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    d32.start_i = 1'b0; d32.annul_i = 1'b0; d32.signed_div_i = 1'b0;
    d32.opdata1_i = 32'd0; d32.opdata2_i = 32'd0;
    d8.start_i = 1'b0; d8.annul_i = 1'b0; d8.signed_div_i = 1'b0;
    d8.opdata1_i = 8'd0; d8.opdata2_i = 8'd0;
    tick(); tick(); tick();
    rst = 1'b0;
    chk("reset32", {d32.result_o[60:0], d32.ready_o, d32.busy_o, d32.div_by_zero_o}, 64'd0);
    chk("reset8", {44'd0, d8.result_o, d8.ready_o, d8.busy_o, d8.div_by_zero_o}, 64'd0);

    // Main 32-bit cases: normal latency is WIDTH+1 edges after the accept edge.
    do32("u100_7",    1'b0, 32'd100,        32'd7,        33, {32'd2, 32'd14},                  1'b0, 1'b0);
    do32("s_m7_2",    1'b1, 32'hFFFF_FFF9,  32'h0000_0002, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD},  1'b0, 1'b1);
    do32("s_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 33, {32'h0, 32'h8000_0000},         1'b0, 1'b0);
    do32("u_max_max", 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 33, {32'h0, 32'h1},                 1'b0, 1'b0);
    do32("dbz",       1'b0, 32'h0000_1234,  32'h0,         1,  {32'h0000_1234, 32'hFFFF_FFFF}, 1'b1, 1'b0);

    // Annul at CALC step 10, then immediately start 9/3.
    d32.start_i = 1'b1; d32.signed_div_i = 1'b0;
    d32.opdata1_i = 32'd1000; d32.opdata2_i = 32'd7;
    tick();
    rose = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (d32.ready_o) rose = 1'b1;
    end
    d32.annul_i = 1'b1;
    tick();
    chk("annul_idle", {62'd0, d32.busy_o, d32.ready_o}, 64'd0);
    chk("annul_noready", {63'd0, rose}, 64'd0);
    do32("after_annul", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3}, 1'b0, 1'b0);

    // Reset in the middle of CALC.
    d32.start_i = 1'b1; d32.signed_div_i = 1'b0;
    d32.opdata1_i = 32'd100; d32.opdata2_i = 32'd7;
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_busy", {63'd0, d32.busy_o}, 64'd1);
    rst = 1'b1;
    d32.start_i = 1'b0;
    tick();
    chk("rst_mid", {d32.result_o[60:0], d32.ready_o, d32.busy_o, d32.div_by_zero_o}, 64'd0);
    rst = 1'b0;
    tick();

    // Narrow instance.
    do8("n_u200_3",  1'b0, 8'd200, 8'd3, 9, {8'd2, 8'd66},   1'b0);
    do8("n_s_m128_3", 1'b1, 8'h80,  8'd3, 9, {8'hFE, 8'hD6}, 1'b0);
    do8("n_dbz",     1'b1, 8'hFB,  8'd0, 1, {8'hFB, 8'hFF}, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
